// File: rtl/conv_pkg.sv
// Shared constants for the convolution window controller and its datapath.
// Holds the default kernel geometry and the frame-sequencer state encodings.
package conv_pkg;

  localparam int unsigned CONV_SIZE      = 3;
  localparam int unsigned CONV_WIDTH_BIT = 8;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_STREAM = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of storage: combinational read and synchronous write at a
// shared column address, so a read returns the value from the previous row.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH_BIT = CONV_WIDTH_BIT
) (
  input  logic                                   clock,
  input  logic                                   i_we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] i_addr,
  input  logic [WIDTH_BIT-1:0]                   i_wdata,
  output logic [WIDTH_BIT-1:0]                   o_rdata
);

  logic [WIDTH_BIT-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Contents need no reset: every column is rewritten before it is consumed.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Streaming SIZE x SIZE window scheduler: line buffers, window register and a
// per-frame sequencer feeding a combinational convolution unit.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned SIZE      = CONV_SIZE,
  parameter int unsigned WIDTH_BIT = CONV_WIDTH_BIT,
  parameter int unsigned IMG_W     = 8,
  parameter int unsigned IMG_H     = 8
) (
  input  logic                                       clock,
  input  logic                                       nreset,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       frame_done,
  input  logic signed [WIDTH_BIT-1:0]                in_pixel,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]   win,
  input  logic signed [WIDTH_BIT-1:0]                conv_res,
  output logic signed [WIDTH_BIT-1:0]                out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_next_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_out_valid;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] r_win;

  logic w_accept;
  logic w_col_last;
  logic w_last_pix;
  logic w_produce;
  logic w_frame_start;

  logic [WIDTH_BIT-1:0] w_lb_rd  [SIZE-1];
  logic [WIDTH_BIT-1:0] w_new_col [SIZE];

  assign in_ready      = (r_state == ST_STREAM) && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_frame_start = (r_state == ST_IDLE) && start;
  assign w_col_last    = (r_col == COL_W'(IMG_W - 1));
  assign w_last_pix    = w_col_last && (r_row == ROW_W'(IMG_H - 1));
  assign w_produce     = (r_row >= ROW_W'(SIZE - 1)) && (r_col >= COL_W'(SIZE - 1));

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign out_valid  = r_out_valid;
  assign win        = r_win;
  assign out_data   = conv_res;

  // Line buffer k holds row r-(SIZE-1-k); each accept shifts column c up a row.
  genvar g_k;
  generate
    for (g_k = 0; g_k < SIZE - 1; g_k++) begin : g_lb
      logic [WIDTH_BIT-1:0] w_wdata;
      if (g_k == SIZE - 2) begin : g_newest
        assign w_wdata = in_pixel;
      end else begin : g_older
        assign w_wdata = w_lb_rd[g_k + 1];
      end

      conv_line_buffer #(
        .DEPTH     (IMG_W),
        .WIDTH_BIT (WIDTH_BIT)
      ) u_line_buffer (
        .clock   (clock),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_wdata),
        .o_rdata (w_lb_rd[g_k])
      );

      assign w_new_col[g_k] = w_lb_rd[g_k];
    end
  endgenerate

  assign w_new_col[SIZE-1] = in_pixel;

  // Frame sequencer next state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_accept && w_last_pix) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_out_valid || out_ready) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_busy       <= (w_next_state != ST_IDLE);
      r_frame_done <= (w_next_state == ST_DONE);
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_pix) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // A new result loads on the same edge an old one retires.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= w_produce;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < int'(SIZE); i++) begin
        for (int j = 0; j < int'(SIZE) - 1; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
        r_win[i][SIZE-1] <= w_new_col[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: a 5x5 instance exercised over several
// frames plus a 3x3 instance for the single-output boundary case.
module tb_conv_window_ctrl;

  typedef logic [2:0][2:0][7:0] win_t;
  typedef struct {
    win_t       win;
    logic [7:0] sum;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] win_sum(input win_t w);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s = s + w[i][j];
    return s;
  endfunction

  // 5x5 instance
  logic       a_nreset = 1'b0, a_start = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic       a_busy, a_frame_done, a_in_ready, a_out_valid;
  logic [7:0] a_in_pixel = 8'd0, a_conv_res, a_out_data;
  win_t       a_win;

  assign a_conv_res = win_sum(a_win);

  conv_window_ctrl #(.SIZE(3), .WIDTH_BIT(8), .IMG_W(5), .IMG_H(5)) dut (
    .clock(clk), .nreset(a_nreset), .start(a_start), .busy(a_busy),
    .frame_done(a_frame_done), .in_pixel(a_in_pixel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .win(a_win), .conv_res(a_conv_res),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  // 3x3 instance
  logic       b_nreset = 1'b0, b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic       b_busy, b_frame_done, b_in_ready, b_out_valid;
  logic [7:0] b_in_pixel = 8'd0, b_conv_res, b_out_data;
  win_t       b_win;

  assign b_conv_res = win_sum(b_win);

  conv_window_ctrl #(.SIZE(3), .WIDTH_BIT(8), .IMG_W(3), .IMG_H(3)) dut3 (
    .clock(clk), .nreset(b_nreset), .start(b_start), .busy(b_busy),
    .frame_done(b_frame_done), .in_pixel(b_in_pixel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .win(b_win), .conv_res(b_conv_res),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  exp_t a_q[$];
  logic [7:0] plan [9] = '{8'd54, 8'd63, 8'd72, 8'd99, 8'd108, 8'd117, 8'd144, 8'd153, 8'd162};
  int a_outs = 0, a_last_hs_cyc = 0, a_fd_cnt = 0, a_fd_cyc = 0;
  int b_outs = 0, b_fd_cnt = 0;

  // Output monitor: every handshake pops one scoreboard entry.
  always @(negedge clk) begin
    if (a_nreset && a_out_valid && a_out_ready) begin
      if (a_q.size() == 0) begin
        check("a_unexpected_out", 32'(a_out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = a_q.pop_front();
        check("a_out_data", 32'(a_out_data), 32'(e.sum));
        for (int i = 0; i < 3; i++)
          check($sformatf("a_win_row%0d", i), 32'(a_win[i]), 32'(e.win[i]));
        if (a_outs < 9) check("a_plan", 32'(a_out_data), 32'(plan[a_outs]));
      end
      a_outs++;
      a_last_hs_cyc = cyc;
    end
    if (a_frame_done) begin
      a_fd_cnt++;
      a_fd_cyc = cyc;
      check("a_busy_at_done", 32'(a_busy), 32'd1);
    end
    if (b_nreset && b_out_valid && b_out_ready) begin
      check("b_out_data", 32'(b_out_data), 32'd126);
      b_outs++;
    end
    if (b_frame_done) b_fd_cnt++;
  end

  task automatic a_start_frame();
    a_outs = 0;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_busy_after_start", 32'(a_busy), 32'd1);
  endtask

  // Drive pixels 0..npix-1; stimulus side pushes expected results on accept.
  task automatic a_feed(input bit rnd, input bit bp, input int npix);
    int   idx = 0;
    int   guard = 0;
    bit   bp_done = 1'b0;
    int   r, c;
    exp_t e;
    while (idx < npix && guard < 1000) begin
      guard++;
      a_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a_in_pixel = 8'(idx);
      a_start    = (idx == 8);
      @(negedge clk);
      if (a_in_valid && a_in_ready) begin
        r = idx / 5;
        c = idx % 5;
        if (r >= 2 && c >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.win[i][j] = 8'((r - 2 + i) * 5 + (c - 2 + j));
          e.sum = win_sum(e.win);
          a_q.push_back(e);
        end
        idx++;
      end
      @(posedge clk); #1;
      a_start = 1'b0;
      if (bp && !bp_done && a_out_valid && a_outs == 2 && a_q.size() > 0) begin
        a_out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready", 32'(a_in_ready), 32'd0);
          check("bp_out_valid", 32'(a_out_valid), 32'd1);
          check("bp_out_data", 32'(a_out_data), 32'd72);
          check("bp_win_row2", 32'(a_win[2]), 32'(a_q[0].win[2]));
          @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        bp_done = 1'b1;
      end
    end
    a_in_valid = 1'b0;
    check("a_feed_complete", 32'(idx), 32'(npix));
    if (bp) check("bp_exercised", 32'(bp_done), 32'd1);
  endtask

  task automatic a_finish_frame();
    int g = 0;
    int fd0 = a_fd_cnt;
    while (a_fd_cnt == fd0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("a_done_timeout", 32'(g < 100), 32'd1);
    @(negedge clk);
    check("a_busy_fall", 32'(a_busy), 32'd0);
    check("a_done_latency", 32'(a_fd_cyc - a_last_hs_cyc), 32'd1);
    check("a_out_count", 32'(a_outs), 32'd9);
    check("a_done_pulses", 32'(a_fd_cnt - fd0), 32'd1);
    check("a_queue_empty", 32'(a_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int fd_before;
    int g;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_frame_done", 32'(a_frame_done), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    for (int i = 0; i < 3; i++) check("rst_win", 32'(a_win[i]), 32'd0);
    @(posedge clk); #1;
    a_nreset = 1'b1;
    b_nreset = 1'b1;
    @(posedge clk); #1;

    // Plain frame, with start poked mid-stream.
    a_start_frame();
    a_feed(1'b0, 1'b0, 25);
    a_finish_frame();

    // Output backpressure at the third result.
    a_start_frame();
    a_feed(1'b0, 1'b1, 25);
    a_finish_frame();

    // Randomly gapped input.
    a_start_frame();
    a_feed(1'b1, 1'b0, 25);
    a_finish_frame();

    // Abort after pixel 15 with reset.
    fd_before = a_fd_cnt;
    a_start_frame();
    a_feed(1'b0, 1'b0, 16);
    a_nreset = 1'b0;
    @(posedge clk); #1;
    a_nreset = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(a_out_valid), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_in_ready", 32'(a_in_ready), 32'd0);
    check("abort_out_data", 32'(a_out_data), 32'd0);
    check("abort_frame_done", 32'(a_frame_done), 32'd0);
    a_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(a_fd_cnt), 32'(fd_before));

    a_start_frame();
    a_feed(1'b0, 1'b0, 25);
    a_finish_frame();

    // 3x3 frame yields a single full-image result.
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int idx = 0; idx < 9; idx++) begin
      b_in_pixel = 8'(10 + idx);
      b_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    g = 0;
    while (b_fd_cnt == 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    check("b_done_timeout", 32'(g < 50), 32'd1);
    @(negedge clk);
    check("b_out_count", 32'(b_outs), 32'd1);
    check("b_done_pulses", 32'(b_fd_cnt), 32'd1);
    check("b_busy_fall", 32'(b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
